// File: rtl/sync_fifo_cfg.sv
// Synchronous FIFO with programmable almost-full / almost-empty limits,
// config readback on the data port, and pulsed plus sticky error flags.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_wr_en, i_rd_en    push / pop requests
//   i_data_in           push data, also the config write value
//   i_cfg_wr, i_cfg_rd  limit write / readback (override push / pop)
//   i_cfg_sel           0 = almost-full limit, 1 = almost-empty limit
//   i_err_clr           clears the sticky error bits
//   o_data_out          registered pop data or limit readback
//   o_rd_valid          o_data_out loaded with a FIFO word this cycle
//   o_full, o_empty     occupancy flags
//   o_almost_full       full or count >= almost-full limit
//   o_almost_empty      empty or count <= almost-empty limit
//   o_count             occupancy, 0..DEPTH
//   o_overflow          one-cycle pulse after a push attempted while full
//   o_underflow         one-cycle pulse after a pop attempted while empty
//   o_ovf_sticky        latched overflow, held until i_err_clr
//   o_udf_sticky        latched underflow, held until i_err_clr
module sync_fifo_cfg #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_RST = DEPTH / 2,
    parameter int AE_RST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic                    i_rd_en,
    input  logic [DATA_W-1:0]       i_data_in,
    input  logic                    i_cfg_wr,
    input  logic                    i_cfg_rd,
    input  logic                    i_cfg_sel,
    input  logic                    i_err_clr,
    output logic [DATA_W-1:0]       o_data_out,
    output logic                    o_rd_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    output logic                    o_underflow,
    output logic                    o_ovf_sticky,
    output logic                    o_udf_sticky
);

    localparam int AW = $clog2(DEPTH);
    // Wide enough to hold both the full data word and the value DEPTH,
    // so saturation sees every bit of the written value.
    localparam int XW = (DATA_W > AW + 1) ? DATA_W : AW + 1;

    localparam logic [AW:0]   LIM_MAX   = (AW + 1)'(DEPTH);
    localparam logic [XW-1:0] LIM_MAX_X = XW'(DEPTH);
    localparam logic [AW:0]   AF_INIT   = (AW + 1)'(AF_RST);
    localparam logic [AW:0]   AE_INIT   = (AW + 1)'(AE_RST);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       r_af_lim;
    logic [AW:0]       r_ae_lim;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_udf;
    logic              r_ovf_st;
    logic              r_udf_st;

    logic [AW:0]       w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_ev;
    logic              w_udf_ev;
    logic [XW-1:0]     w_din_x;
    logic [AW:0]       w_cfg_val;
    logic [AW:0]       w_lim_sel;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign w_push   = i_wr_en & ~i_cfg_wr & ~w_full;
    assign w_pop    = i_rd_en & ~i_cfg_rd & ~w_empty;
    assign w_ovf_ev = i_wr_en & ~i_cfg_wr & w_full;
    assign w_udf_ev = i_rd_en & ~i_cfg_rd & w_empty;

    assign w_din_x   = XW'(i_data_in);
    assign w_cfg_val = (w_din_x > LIM_MAX_X) ? LIM_MAX : w_din_x[AW:0];
    assign w_lim_sel = i_cfg_sel ? r_ae_lim : r_af_lim;

    // Storage is not cleared by reset; writes are simply blocked during it.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_af_lim   <= AF_INIT;
            r_ae_lim   <= AE_INIT;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_ovf_st   <= 1'b0;
            r_udf_st   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_cfg_wr) begin
                if (i_cfg_sel) begin
                    r_ae_lim <= w_cfg_val;
                end else begin
                    r_af_lim <= w_cfg_val;
                end
            end
            if (i_cfg_rd) begin
                r_data_out <= DATA_W'(w_lim_sel);
            end else if (w_pop) begin
                r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
            end
            r_rd_valid <= w_pop;
            r_ovf      <= w_ovf_ev;
            r_udf      <= w_udf_ev;
            // A new error in the clearing cycle still latches.
            if (w_ovf_ev) begin
                r_ovf_st <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf_st <= 1'b0;
            end
            if (w_udf_ev) begin
                r_udf_st <= 1'b1;
            end else if (i_err_clr) begin
                r_udf_st <= 1'b0;
            end
        end
    end

    assign o_data_out     = r_data_out;
    assign o_rd_valid     = r_rd_valid;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = w_full | (w_count >= r_af_lim);
    assign o_almost_empty = w_empty | (w_count <= r_ae_lim);
    assign o_count        = w_count;
    assign o_overflow     = r_ovf;
    assign o_underflow    = r_udf;
    assign o_ovf_sticky   = r_ovf_st;
    assign o_udf_sticky   = r_udf_st;

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Directed self-checking bench for sync_fifo_cfg (DATA_W=8, DEPTH=16).
// One task per scenario, each with its own inline comparisons.
module tb_sync_fifo_cfg;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic       cfg_wr;
    logic       cfg_rd;
    logic       cfg_sel;
    logic       err_clr;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       ovf_sticky;
    logic       udf_sticky;

    int checks = 0;
    int fails  = 0;

    sync_fifo_cfg #(.DATA_W(8), .DEPTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wr_en        (wr_en),
        .i_rd_en        (rd_en),
        .i_data_in      (data_in),
        .i_cfg_wr       (cfg_wr),
        .i_cfg_rd       (cfg_rd),
        .i_cfg_sel      (cfg_sel),
        .i_err_clr      (err_clr),
        .o_data_out     (data_out),
        .o_rd_valid     (rd_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_underflow    (underflow),
        .o_ovf_sticky   (ovf_sticky),
        .o_udf_sticky   (udf_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; data_in = 8'h00;
        cfg_wr = 0; cfg_rd = 0; cfg_sel = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL rst_dout got=%0h exp=0", data_out); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rdv got=%0b exp=0", rd_valid); end
        checks++; if ({full, almost_full, almost_empty} !== 3'b001) begin
            fails++; $display("FAIL rst_flags got=%b exp=001", {full, almost_full, almost_empty});
        end
        checks++; if ({overflow, underflow, ovf_sticky, udf_sticky} !== 4'b0000) begin
            fails++; $display("FAIL rst_err got=%b exp=0000", {overflow, underflow, ovf_sticky, udf_sticky});
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1; data_in = 8'(i);
            step();
            checks++; if (count !== 5'(i)) begin fails++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            checks++; if (almost_full !== (i >= 8)) begin fails++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, almost_full, (i >= 8)); end
            checks++; if (full !== (i == 16)) begin fails++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full, (i == 16)); end
        end
        data_in = 8'h11;
        step();
        wr_en = 0;
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse got=%0b exp=1", overflow); end
        checks++; if (ovf_sticky !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%0b exp=1", ovf_sticky); end
        checks++; if (count !== 5'd16) begin fails++; $display("FAIL ovf_count got=%0d exp=16", count); end
        step();
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_end got=%0b exp=0", overflow); end
        checks++; if (ovf_sticky !== 1'b1) begin fails++; $display("FAIL ovf_hold got=%0b exp=1", ovf_sticky); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1;
            step();
            checks++; if (data_out !== 8'(i)) begin fails++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, data_out, i); end
            checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL drain_rdv[%0d] got=%0b exp=1", i, rd_valid); end
            checks++; if (count !== 5'(16 - i)) begin fails++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 16 - i); end
            checks++; if (almost_empty !== (i >= 15)) begin fails++; $display("FAIL drain_ae[%0d] got=%0b exp=%0b", i, almost_empty, (i >= 15)); end
        end
        step();
        rd_en = 0;
        checks++; if (underflow !== 1'b1) begin fails++; $display("FAIL udf_pulse got=%0b exp=1", underflow); end
        checks++; if (udf_sticky !== 1'b1) begin fails++; $display("FAIL udf_sticky got=%0b exp=1", udf_sticky); end
        checks++; if (data_out !== 8'h10) begin fails++; $display("FAIL udf_dout got=%0h exp=10", data_out); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL udf_rdv got=%0b exp=0", rd_valid); end
        step();
        checks++; if (underflow !== 1'b0) begin fails++; $display("FAIL udf_end got=%0b exp=0", underflow); end
        checks++; if (data_out !== 8'h10) begin fails++; $display("FAIL idle_hold got=%0h exp=10", data_out); end
    endtask

    task automatic test_err_clr();
        // Underflow in the clear cycle: udf stays set, ovf clears.
        err_clr = 1; rd_en = 1;
        step();
        rd_en = 0;
        checks++; if (udf_sticky !== 1'b1) begin fails++; $display("FAIL clr_setwins got=%0b exp=1", udf_sticky); end
        checks++; if (ovf_sticky !== 1'b0) begin fails++; $display("FAIL clr_ovf got=%0b exp=0", ovf_sticky); end
        step();
        err_clr = 0;
        checks++; if (udf_sticky !== 1'b0) begin fails++; $display("FAIL clr_udf got=%0b exp=0", udf_sticky); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1; data_in = 8'(8'h40 + i);
            step();
        end
        wr_en = 0;
        checks++; if (count !== 5'd10) begin fails++; $display("FAIL wrap_c10 got=%0d exp=10", count); end
        for (int i = 0; i < 10; i++) begin
            rd_en = 1;
            step();
            checks++; if (data_out !== 8'(8'h40 + i)) begin fails++; $display("FAIL wrap_a[%0d] got=%0h exp=%0h", i, data_out, 8'h40 + i); end
        end
        rd_en = 0;
        for (int i = 0; i < 12; i++) begin
            wr_en = 1; data_in = 8'(8'h60 + i);
            step();
            checks++; if (count !== 5'(i + 1)) begin fails++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, count, i + 1); end
        end
        wr_en = 0;
        for (int i = 0; i < 12; i++) begin
            rd_en = 1;
            step();
            checks++; if (data_out !== 8'(8'h60 + i)) begin fails++; $display("FAIL wrap_b[%0d] got=%0h exp=%0h", i, data_out, 8'h60 + i); end
        end
        rd_en = 0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_simul();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; data_in = 8'(8'h80 + i);
            step();
        end
        // Full: pop proceeds, push rejected.
        data_in = 8'hEE; rd_en = 1;
        step();
        wr_en = 0; rd_en = 0;
        checks++; if (count !== 5'd15) begin fails++; $display("FAIL sim_full_cnt got=%0d exp=15", count); end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL sim_full_ovf got=%0b exp=1", overflow); end
        checks++; if (data_out !== 8'h80) begin fails++; $display("FAIL sim_full_dout got=%0h exp=80", data_out); end
        for (int i = 0; i < 15; i++) begin
            rd_en = 1;
            step();
        end
        checks++; if (data_out !== 8'h8F) begin fails++; $display("FAIL sim_last got=%0h exp=8f", data_out); end
        // Empty: push proceeds, pop rejected.
        wr_en = 1; data_in = 8'h77;
        step();
        wr_en = 0;
        checks++; if (count !== 5'd1) begin fails++; $display("FAIL sim_empty_cnt got=%0d exp=1", count); end
        checks++; if (underflow !== 1'b1) begin fails++; $display("FAIL sim_empty_udf got=%0b exp=1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL sim_empty_rdv got=%0b exp=0", rd_valid); end
        step();
        rd_en = 0;
        checks++; if (data_out !== 8'h77) begin fails++; $display("FAIL sim_pop77 got=%0h exp=77", data_out); end
    endtask

    task automatic test_config();
        do_reset();
        cfg_rd = 1; cfg_sel = 0;
        step();
        checks++; if (data_out !== 8'h08) begin fails++; $display("FAIL cfg_af_rst got=%0h exp=08", data_out); end
        cfg_rd = 0; cfg_wr = 1; wr_en = 1; data_in = 8'h05;
        step();
        cfg_wr = 0; wr_en = 0;
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL cfg_nopush got=%0d exp=0", count); end
        cfg_rd = 1; rd_en = 1;
        step();
        cfg_rd = 0; rd_en = 0;
        checks++; if (data_out !== 8'h05) begin fails++; $display("FAIL cfg_rb5 got=%0h exp=05", data_out); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL cfg_rdv got=%0b exp=0", rd_valid); end
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1; data_in = 8'(i);
            step();
            checks++; if (almost_full !== (i >= 5)) begin fails++; $display("FAIL cfg_af[%0d] got=%0b exp=%0b", i, almost_full, (i >= 5)); end
        end
        wr_en = 0;
        cfg_wr = 1; data_in = 8'h40;
        step();
        cfg_wr = 0; cfg_rd = 1;
        step();
        cfg_rd = 0;
        checks++; if (data_out !== 8'h10) begin fails++; $display("FAIL cfg_sat got=%0h exp=10", data_out); end
        checks++; if (almost_full !== 1'b0) begin fails++; $display("FAIL cfg_af16 got=%0b exp=0", almost_full); end
        checks++; if (count !== 5'd5) begin fails++; $display("FAIL cfg_cnt5 got=%0d exp=5", count); end
        cfg_rd = 1; cfg_sel = 1;
        step();
        checks++; if (data_out !== 8'h01) begin fails++; $display("FAIL cfg_ae_rst got=%0h exp=01", data_out); end
        checks++; if (almost_empty !== 1'b0) begin fails++; $display("FAIL cfg_ae_lo got=%0b exp=0", almost_empty); end
        cfg_rd = 0; cfg_wr = 1; data_in = 8'h05;
        step();
        cfg_wr = 0; cfg_sel = 0;
        checks++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL cfg_ae_hi got=%0b exp=1", almost_empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; data_in = 8'(8'hA0 + i);
            step();
        end
        wr_en = 0; rd_en = 1;
        step();
        checks++; if (count !== 5'd7) begin fails++; $display("FAIL mid_pre_cnt got=%0d exp=7", count); end
        checks++; if (data_out !== 8'hA0) begin fails++; $display("FAIL mid_pre_dout got=%0h exp=a0", data_out); end
        rst_n = 0; wr_en = 1; cfg_wr = 1; data_in = 8'h03;
        step();
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL mid_empty got=%0b exp=1", empty); end
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL mid_dout got=%0h exp=0", data_out); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL mid_rdv got=%0b exp=0", rd_valid); end
        idle();
        rst_n = 1; cfg_rd = 1; cfg_sel = 0;
        step();
        cfg_rd = 0;
        checks++; if (data_out !== 8'h08) begin fails++; $display("FAIL mid_aflim got=%0h exp=08", data_out); end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_err_clr();
        test_wrap();
        test_simul();
        test_config();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
